// File: rtl/ttt_pkg.sv
// Shared square codes and FSM state encodings for the tic-tac-toe move controller.
package ttt_pkg;

  localparam int unsigned NUM_SQUARES = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PL1   = 2'b01,
    PL2   = 2'b10
  } square_t;

  typedef enum logic [2:0] {
    P1_WAIT  = 3'd0,
    P1_CHECK = 3'd1,
    P2_WAIT  = 3'd2,
    P2_CHECK = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/board_move_ctrl.sv
// Board move controller: takes turns, validates moves against the external occupancy detector, writes squares.
// Optional per-turn idle timeout is compiled in with `define MOVE_TIMEOUT_EN.
module board_move_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic [8:0] move_sel,
  input  logic       new_game,
  input  logic       game_over,
  input  logic       illegal_move,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [8:0] PL1_en,
  output logic [8:0] PL2_en,
  output logic       turn,
`ifdef MOVE_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic       move_err,
  output logic       no_space
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                        state_q, state_d;
  square_t [NUM_SQUARES-1:0]     pos_q, pos_d;
  logic    [8:0]                 move_q, move_d;
  logic                          turn_q, turn_d;
  logic                          move_err_q, move_err_d;
  logic                          no_space_q, no_space_d;
  logic                          move_onehot;
  logic                          board_full;
  square_t                       player_code;

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             timeout_hit;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // A latched move is only usable when exactly one square is selected.
  assign move_onehot = (move_q != '0) && ((move_q & (move_q - 9'd1)) == '0);
  assign player_code = (state_q == P2_CHECK) ? PL2 : PL1;

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    move_d     = move_q;
    turn_d     = turn_q;
    move_err_d = 1'b0;
    no_space_d = no_space_q;
    board_full = 1'b0;
    PL1_en     = '0;
    PL2_en     = '0;
`ifdef MOVE_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif

    if (state_q == P1_CHECK && move_onehot) PL1_en = move_q;
    if (state_q == P2_CHECK && move_onehot) PL2_en = move_q;

    if (new_game) begin
      state_d    = P1_WAIT;
      turn_d     = 1'b0;
      move_d     = '0;
      no_space_d = 1'b0;
      for (int i = 0; i < NUM_SQUARES; i++) pos_d[i] = EMPTY;
    end else if (game_over) begin
      // Winner logic overrides any write pending in a CHECK state.
      state_d = DONE;
    end else begin
      unique case (state_q)
        P1_WAIT, P2_WAIT: begin
          if (play) begin
            move_d  = move_sel;
            state_d = (state_q == P1_WAIT) ? P1_CHECK : P2_CHECK;
          end
`ifdef MOVE_TIMEOUT_EN
          else if (timeout_hit) begin
            timeout_d = 1'b1;
            turn_d    = ~turn_q;
            state_d   = (state_q == P1_WAIT) ? P2_WAIT : P1_WAIT;
          end
`endif
        end
        P1_CHECK, P2_CHECK: begin
          if (illegal_move || !move_onehot) begin
            move_err_d = 1'b1;
            state_d    = (state_q == P1_CHECK) ? P1_WAIT : P2_WAIT;
          end else begin
            for (int i = 0; i < NUM_SQUARES; i++) begin
              if (move_q[i]) pos_d[i] = player_code;
            end
            turn_d     = ~turn_q;
            state_d    = (state_q == P1_CHECK) ? P2_WAIT : P1_WAIT;
            board_full = 1'b1;
            for (int i = 0; i < NUM_SQUARES; i++) begin
              if (pos_d[i] == EMPTY) board_full = 1'b0;
            end
            if (board_full) begin
              state_d    = DONE;
              no_space_d = 1'b1;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = P1_WAIT;
      endcase
    end

`ifdef MOVE_TIMEOUT_EN
    // Counter only runs while a player sits in the same WAIT state.
    if (new_game || (state_d != state_q) || !(state_q == P1_WAIT || state_q == P2_WAIT))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments; the nine squares are plain flops, so resetting them is cheap and required.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= P1_WAIT;
      for (int i = 0; i < NUM_SQUARES; i++) pos_q[i] <= EMPTY;
      move_q     <= '0;
      turn_q     <= 1'b0;
      move_err_q <= 1'b0;
      no_space_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      move_q     <= move_d;
      turn_q     <= turn_d;
      move_err_q <= move_err_d;
      no_space_q <= no_space_d;
`ifdef MOVE_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign pos1     = pos_q[0];
  assign pos2     = pos_q[1];
  assign pos3     = pos_q[2];
  assign pos4     = pos_q[3];
  assign pos5     = pos_q[4];
  assign pos6     = pos_q[5];
  assign pos7     = pos_q[6];
  assign pos8     = pos_q[7];
  assign pos9     = pos_q[8];
  assign turn     = turn_q;
  assign move_err = move_err_q;
  assign no_space = no_space_q;
`ifdef MOVE_TIMEOUT_EN
  assign timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed testbench for board_move_ctrl; define MOVE_TIMEOUT_EN to also exercise the idle timeout.
module tb_board_move_ctrl;

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 8;
`else
  localparam int unsigned TO_CYCLES = 100000000;
`endif

  logic        clock = 1'b0;
  logic        reset, play, new_game, game_over, illegal_move;
  logic [8:0]  move_sel;
  logic [1:0]  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [8:0]  pl1_en, pl2_en;
  logic        turn, move_err, no_space;
`ifdef MOVE_TIMEOUT_EN
  logic        timeout;
`endif
  logic [17:0] board;

  int checks = 0;
  int errors = 0;

  board_move_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clock(clock), .reset(reset), .play(play), .move_sel(move_sel),
    .new_game(new_game), .game_over(game_over), .illegal_move(illegal_move),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .PL1_en(pl1_en), .PL2_en(pl2_en), .turn(turn),
`ifdef MOVE_TIMEOUT_EN
    .timeout(timeout),
`endif
    .move_err(move_err), .no_space(no_space)
  );

  always #5 clock = ~clock;

  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic do_move(input logic [8:0] sq);
    play = 1'b1; move_sel = sq;
    step();
    play = 1'b0; move_sel = '0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0; new_game = 1'b0; game_over = 1'b0;
    illegal_move = 1'b0; move_sel = '0;
    #12;
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL reset_board got %h want %h", board, 18'h0); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %b want 0", turn); end
    checks++; if ({pl1_en, pl2_en} !== 18'h0) begin errors++; $display("FAIL reset_pl_en got %h want 0", {pl1_en, pl2_en}); end
    checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL reset_move_err got %b want 0", move_err); end
    checks++; if (no_space !== 1'b0) begin errors++; $display("FAIL reset_no_space got %b want 0", no_space); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_first_move();
    play = 1'b1; move_sel = 9'h001;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (pl1_en !== 9'h001) begin errors++; $display("FAIL first_pl1_en got %h want 001", pl1_en); end
    checks++; if (pl2_en !== 9'h000) begin errors++; $display("FAIL first_pl2_en got %h want 000", pl2_en); end
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL first_board_early got %h want 0", board); end
    step();
    checks++; if (board !== 18'h1) begin errors++; $display("FAIL first_board got %h want 00001", board); end
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL first_turn got %b want 1", turn); end
    checks++; if (pl1_en !== 9'h000) begin errors++; $display("FAIL first_pl1_en_after got %h want 000", pl1_en); end
  endtask

  task automatic test_illegal();
    play = 1'b1; move_sel = 9'h001; illegal_move = 1'b1;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (pl2_en !== 9'h001) begin errors++; $display("FAIL illegal_pl2_en got %h want 001", pl2_en); end
    checks++; if (pl1_en !== 9'h000) begin errors++; $display("FAIL illegal_pl1_en got %h want 000", pl1_en); end
    step();
    illegal_move = 1'b0;
    checks++; if (move_err !== 1'b1) begin errors++; $display("FAIL illegal_move_err got %b want 1", move_err); end
    checks++; if (board !== 18'h1) begin errors++; $display("FAIL illegal_board got %h want 00001", board); end
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL illegal_turn got %b want 1", turn); end
    step();
    checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got %b want 0", move_err); end
  endtask

  task automatic test_not_onehot();
    play = 1'b1; move_sel = 9'h003;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if ({pl1_en, pl2_en} !== 18'h0) begin errors++; $display("FAIL multi_pl_en got %h want 0", {pl1_en, pl2_en}); end
    step();
    checks++; if (move_err !== 1'b1) begin errors++; $display("FAIL multi_move_err got %b want 1", move_err); end
    checks++; if (board !== 18'h1) begin errors++; $display("FAIL multi_board got %h want 00001", board); end
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL multi_turn got %b want 1", turn); end
    step();
  endtask

  task automatic test_full_board();
    logic [17:0] exp_board;
    logic [3:0]  order [9];
    order = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
    exp_board = '0;
    start_new_game();
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL full_clear got %h want 0", board); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL full_clear_turn got %b want 0", turn); end
    for (int k = 0; k < 9; k++) begin
      do_move(9'h001 << (order[k] - 4'd1));
      exp_board[2*(order[k]-1) +: 2] = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (board !== exp_board) begin errors++; $display("FAIL full_move%0d board got %h want %h", k, board, exp_board); end
      checks++; if (no_space !== (k == 8)) begin errors++; $display("FAIL full_move%0d no_space got %b want %b", k, no_space, k == 8); end
      if (k < 8) begin
        checks++; if (turn !== ((k % 2) == 0)) begin errors++; $display("FAIL full_move%0d turn got %b want %b", k, turn, (k % 2) == 0); end
      end
    end
    play = 1'b1; move_sel = 9'h001;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if ({pl1_en, pl2_en} !== 18'h0) begin errors++; $display("FAIL done_pl_en got %h want 0", {pl1_en, pl2_en}); end
    step();
    checks++; if (board !== exp_board) begin errors++; $display("FAIL done_board got %h want %h", board, exp_board); end
    checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL done_move_err got %b want 0", move_err); end
    checks++; if (no_space !== 1'b1) begin errors++; $display("FAIL done_no_space got %b want 1", no_space); end
    start_new_game();
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL newgame_board got %h want 0", board); end
    checks++; if (no_space !== 1'b0) begin errors++; $display("FAIL newgame_no_space got %b want 0", no_space); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL newgame_turn got %b want 0", turn); end
    play = 1'b1; move_sel = 9'h002;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (pl1_en !== 9'h002) begin errors++; $display("FAIL newgame_pl1_en got %h want 002", pl1_en); end
    step();
    checks++; if (board !== 18'h4) begin errors++; $display("FAIL newgame_move got %h want 00004", board); end
  endtask

  task automatic test_play_during_check();
    start_new_game();
    play = 1'b1; move_sel = 9'h001;
    step();
    move_sel = 9'h002;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (board !== 18'h1) begin errors++; $display("FAIL noqueue_board got %h want 00001", board); end
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL noqueue_turn got %b want 1", turn); end
    step();
    checks++; if ({pl1_en, pl2_en} !== 18'h0) begin errors++; $display("FAIL noqueue_pl_en got %h want 0", {pl1_en, pl2_en}); end
    step();
    checks++; if (board !== 18'h1) begin errors++; $display("FAIL noqueue_board_after got %h want 00001", board); end
  endtask

  task automatic test_game_over();
    start_new_game();
    play = 1'b1; move_sel = 9'h002;
    step();
    play = 1'b0; move_sel = '0;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL gameover_board got %h want 0", board); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL gameover_turn got %b want 0", turn); end
    checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL gameover_move_err got %b want 0", move_err); end
    play = 1'b1; move_sel = 9'h001;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (pl1_en !== 9'h000) begin errors++; $display("FAIL gameover_frozen_pl1 got %h want 000", pl1_en); end
    step();
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL gameover_frozen_board got %h want 0", board); end
    start_new_game();
    play = 1'b1; move_sel = 9'h001;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (pl1_en !== 9'h001) begin errors++; $display("FAIL gameover_restart_pl1 got %h want 001", pl1_en); end
    step();
  endtask

  task automatic test_reset_mid_check();
    start_new_game();
    do_move(9'h001);
    do_move(9'h002);
    checks++; if (board !== 18'h9) begin errors++; $display("FAIL midreset_setup got %h want 00009", board); end
    play = 1'b1; move_sel = 9'h004;
    step();
    play = 1'b0; move_sel = '0;
    checks++; if (pl1_en !== 9'h004) begin errors++; $display("FAIL midreset_pl1 got %h want 004", pl1_en); end
    #2 reset = 1'b1;
    #1;
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL midreset_board got %h want 0", board); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL midreset_turn got %b want 0", turn); end
    checks++; if (pl1_en !== 9'h000) begin errors++; $display("FAIL midreset_pl1_after got %h want 000", pl1_en); end
    #2 reset = 1'b0;
    step();
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL midreset_nowrite got %h want 0", board); end
    checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL midreset_move_err got %b want 0", move_err); end
  endtask

`ifdef MOVE_TIMEOUT_EN
  task automatic test_timeout();
    start_new_game();
    for (int i = 1; i < 8; i++) begin
      step();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early%0d got %b want 0", i, timeout); end
    end
    step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b want 1", timeout); end
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL timeout_turn got %b want 1", turn); end
    checks++; if (board !== 18'h0) begin errors++; $display("FAIL timeout_board got %h want 0", board); end
    step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle got %b want 0", timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_move();
    test_illegal();
    test_not_onehot();
    test_full_board();
    test_play_during_check();
    test_game_over();
    test_reset_mid_check();
`ifdef MOVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_move_ctrl.md
BOARD_MOVE_CTRL -- requirements
Module: board_move_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, cycles a player may idle before forfeiting the turn (used only with MOVE_TIMEOUT_EN).
REQ-002 SHALL have port clock  in  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port play  in  1  single-cycle synchronous pulse requesting commit of move_sel.
REQ-005 SHALL have port move_sel  in  9  requested square, one-hot, bit0 = square 1.
REQ-006 SHALL have port new_game  in  1  synchronous pulse that clears the board and starts a new game.
REQ-007 SHALL have port game_over  in  1  level from the external winner logic that freezes the board.
REQ-008 SHALL have port illegal_move  in  1  combinational occupancy verdict from the external detector for the current PL1_en/PL2_en.
REQ-009 SHALL have ports pos1..pos9  out  2 each  square state: 00 empty, 01 player 1, 10 player 2; 11 never driven.
REQ-010 SHALL have ports PL1_en, PL2_en  out  9 each  one-hot candidate move for the external detector.
REQ-011 SHALL have port turn  out  1  0 = player 1 to move, 1 = player 2 to move.
REQ-012 SHALL have ports move_err (one-cycle pulse, rejected move) and no_space (level, board full)  out  1 each.

Function
REQ-013 SHALL implement FSM states P1_WAIT, P1_CHECK, P2_WAIT, P2_CHECK, DONE.
REQ-014 In Px_WAIT, play=1 SHALL latch move_sel and enter Px_CHECK the next cycle; play=0 SHALL hold.
REQ-015 In P1_CHECK, PL1_en SHALL equal the latched move when it is one-hot and zero otherwise; PL2_en SHALL be zero. P2_CHECK mirrors this.
REQ-016 Outside CHECK states, PL1_en and PL2_en SHALL be zero.
REQ-017 In Px_CHECK, illegal_move=1 or a non-one-hot latched move SHALL pulse move_err for one cycle, leave the board unchanged and return to Px_WAIT.
REQ-018 Otherwise Px_CHECK SHALL write the player code into the selected pos on the same edge and go to the other player's WAIT, toggling turn.
REQ-019 Latency: play at edge N puts PL_en valid during cycle N+1, and the pos update is visible after edge N+2.
REQ-020 When a write fills the ninth square, the FSM SHALL enter DONE and assert no_space until new_game or reset.
REQ-021 game_over=1 SHALL force DONE from any state on the next edge, with precedence over a CHECK write in the same cycle.
REQ-022 DONE SHALL ignore play; new_game SHALL clear all pos to 00, clear no_space and enter P1_WAIT from any state, with top priority.
REQ-023 play asserted during a CHECK state SHALL be ignored (no queuing).

Reset
REQ-024 Asynchronous reset SHALL set pos1..pos9=00, state=P1_WAIT, turn=0, PL1_en=PL2_en=0, move_err=0, no_space=0, latched move=0 and the timeout counter=0.
REQ-025 Reset asserted mid-CHECK SHALL abort the move with no partial write.

Configuration
REQ-026 With MOVE_TIMEOUT_EN defined, a counter SHALL run in each WAIT state, clear on every state change, and at TIMEOUT_CYCLES-1 pulse output timeout for one cycle and pass the turn without a board write.
REQ-027 Without MOVE_TIMEOUT_EN, the timeout port and counter SHALL be absent, and WAIT states SHALL hold indefinitely.

Structure
REQ-028 Square codes (EMPTY=2'b00, PL1=2'b01, PL2=2'b10) and FSM state encodings SHALL live in shared package ttt_pkg.
REQ-029 The block SHALL have no sub-module; the onehot check and board-full reduction SHALL be inline logic.

Verification
REQ-030 From reset, play with move_sel=9'h001 -> PL1_en=9'h001 for one cycle, then pos1=01 and turn=1.
REQ-031 pos1=01 and P2 plays 9'h001 with the detector returning illegal_move=1 -> one-cycle move_err, pos1 stays 01, turn stays 1.
REQ-032 move_sel=9'h003 -> move_err, PL2_en=0, no write.
REQ-033 Nine legal alternating moves with no win -> no_space=1 and state DONE; a further play is ignored; new_game clears all pos to 00 and sets turn=0.
REQ-034 Reset asserted during P1_CHECK -> all pos=00, turn=0, no write.
REQ-035 With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=8, idle in P1_WAIT -> timeout pulse after 8 cycles, turn=1, board unchanged.
